// File: rtl/pc_rstack_unit_pkg.sv
// Purpose : shared encodings for the PC / return-stack unit (next-PC select, stack ops).
// Latency : n/a (constants only).
// Backpressure: n/a.
package pc_rstack_unit_pkg;

    // Next-PC source select; codes 3,5,6,7 are reserved and hold the PC.
    localparam logic [2:0] PC_SEL_RSTACK = 3'd0;
    localparam logic [2:0] PC_SEL_TARGET = 3'd1;
    localparam logic [2:0] PC_SEL_REL    = 3'd2;
    localparam logic [2:0] PC_SEL_INC    = 3'd4;

    // Return-stack operation codes.
    localparam logic [1:0] RS_NOP       = 2'd0;
    localparam logic [1:0] RS_PUSH_PC   = 2'd1;
    localparam logic [1:0] RS_PUSH_DATA = 2'd2;
    localparam logic [1:0] RS_POP       = 2'd3;

endpackage

// File: rtl/pc_rstack_unit_if.sv
// Purpose : decoder <-> PC unit bundle: control inputs and PC/stack status outputs.
// Latency : n/a (wires only).
// Backpressure: none; controls are sampled every clock edge.
// Ports   : master = decoder side (drives controls), slave = PC unit (drives status).
interface pc_rstack_unit_if #(
    parameter int PC_WIDTH = 16,
    parameter int RS_DEPTH = 16
);
    logic                        PCWrite;
    logic [2:0]                  PCControl;
    logic [1:0]                  RStackOP;
    logic [PC_WIDTH-1:0]         Target;
    logic [PC_WIDTH-1:0]         Offset;
    logic [PC_WIDTH-1:0]         PushData;
    logic                        ClearFlags;
    logic [PC_WIDTH-1:0]         PC_out;
    logic [PC_WIDTH-1:0]         RTop;
    logic [$clog2(RS_DEPTH):0]   RDepth;
    logic                        Overflow;
    logic                        Underflow;

    modport master (
        output PCWrite, PCControl, RStackOP, Target, Offset, PushData, ClearFlags,
        input  PC_out, RTop, RDepth, Overflow, Underflow
    );

    modport slave (
        input  PCWrite, PCControl, RStackOP, Target, Offset, PushData, ClearFlags,
        output PC_out, RTop, RDepth, Overflow, Underflow
    );
endinterface

// File: rtl/pc_rstack_unit_return_stack.sv
// Purpose : LIFO return stack, register array plus depth counter; exposes top/depth/full/empty.
// Latency : push/pop take effect on the clock edge; top/depth are combinational from state.
// Backpressure: none; push when full and pop when empty are ignored (caller flags them).
// Ports   : clk, rst_n (async active-low), i_push, i_pop, i_push_dat, o_top, o_depth, o_full, o_empty.
module return_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_push_dat,
    output logic [W-1:0]             o_top,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [DW-1:0] r_depth;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;
    logic          w_full;
    logic          w_empty;

    assign w_full    = (r_depth == DW'(DEPTH));
    assign w_empty   = (r_depth == '0);
    // Only used while not full, so the low bits equal the depth.
    assign w_wr_idx  = r_depth[AW-1:0];
    assign w_top_idx = AW'(r_depth - DW'(1));

    // Contents need no reset: nothing reads above the depth pointer.
    always_ff @(posedge clk) begin
        if (i_push && !w_full)
            r_mem[w_wr_idx] <= i_push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_depth <= '0;
        else if (i_push && !w_full)
            r_depth <= r_depth + DW'(1);
        else if (i_pop && !w_empty)
            r_depth <= r_depth - DW'(1);
    end

    assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
    assign o_depth = r_depth;
    assign o_full  = w_full;
    assign o_empty = w_empty;
endmodule

// File: rtl/pc_rstack_unit.sv
// Purpose : program counter with next-PC mux (stack top/target/relative/increment) and return stack.
// Latency : PC and stack update 1 cycle after the controls; RTop/RDepth valid the cycle after the op.
// Backpressure: none; faulting stack ops are dropped and flagged (sticky Overflow/Underflow).
// Ports   : CLK, Reset_n (async active-low), bus (pc_rstack_unit_if.slave).
// Config  : define PC_TRAP_EN to force PC to TRAP_VECTOR on any stack fault.
module pc_rstack_unit
    import pc_rstack_unit_pkg::*;
#(
    parameter int                  PC_WIDTH     = 16,
    parameter int                  RS_DEPTH     = 16,
    parameter int                  PC_INC       = 2,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(2)
) (
    input  logic              CLK,
    input  logic              Reset_n,
    pc_rstack_unit_if.slave   bus
);
    logic [PC_WIDTH-1:0]       r_pc;
    logic                      r_ovf;
    logic                      r_unf;
    logic [PC_WIDTH-1:0]       w_pc_nxt;
    logic [PC_WIDTH-1:0]       w_pc_inc;
    logic [PC_WIDTH-1:0]       w_top;
    logic [PC_WIDTH-1:0]       w_push_dat;
    logic [$clog2(RS_DEPTH):0] w_depth;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_ovf_evt;
    logic                      w_unf_evt;
    logic                      w_trap_evt;

    assign w_pc_inc   = r_pc + PC_WIDTH'(PC_INC);
    assign w_push     = (bus.RStackOP == RS_PUSH_PC) || (bus.RStackOP == RS_PUSH_DATA);
    assign w_pop      = (bus.RStackOP == RS_POP);
    // A call pushes the return address computed from the pre-update PC.
    assign w_push_dat = (bus.RStackOP == RS_PUSH_PC) ? w_pc_inc : bus.PushData;
    assign w_ovf_evt  = w_push && w_full;
    assign w_unf_evt  = w_pop && w_empty;

`ifdef PC_TRAP_EN
    assign w_trap_evt = w_ovf_evt || w_unf_evt;
`else
    assign w_trap_evt = 1'b0;
`endif

    return_stack #(
        .W     (PC_WIDTH),
        .DEPTH (RS_DEPTH)
    ) u_rstack (
        .clk        (CLK),
        .rst_n      (Reset_n),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_push_dat (w_push_dat),
        .o_top      (w_top),
        .o_depth    (w_depth),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // w_top is the pre-pop top (0 when empty), so a return on an empty stack loads 0.
    always_comb begin
        w_pc_nxt = r_pc;
        case (bus.PCControl)
            PC_SEL_RSTACK: w_pc_nxt = w_top;
            PC_SEL_TARGET: w_pc_nxt = bus.Target;
            PC_SEL_REL:    w_pc_nxt = r_pc + bus.Offset;
            PC_SEL_INC:    w_pc_nxt = w_pc_inc;
            default:       w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            r_pc <= RESET_VECTOR;
        else if (w_trap_evt)
            r_pc <= TRAP_VECTOR;
        else if (bus.PCWrite)
            r_pc <= w_pc_nxt;
    end

    // Clear wins over a fault raised on the same edge.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (bus.ClearFlags) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_ovf_evt;
            r_unf <= r_unf | w_unf_evt;
        end
    end

    assign bus.PC_out    = r_pc;
    assign bus.RTop      = w_top;
    assign bus.RDepth    = w_depth;
    assign bus.Overflow  = r_ovf;
    assign bus.Underflow = r_unf;
endmodule

// File: tb/tb_pc_rstack_unit.sv
// Purpose : directed self-checking bench for pc_rstack_unit (default parameters).
// Latency : inputs driven 1 time unit after a rising edge; outputs sampled at the same point.
// Backpressure: n/a.
module tb_pc_rstack_unit;
    import pc_rstack_unit_pkg::*;

`ifdef PC_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic CLK;
    logic Reset_n;
    int   n_tot;
    int   n_pass;

    pc_rstack_unit_if #(.PC_WIDTH(16), .RS_DEPTH(16)) bus ();

    pc_rstack_unit #(
        .PC_WIDTH     (16),
        .RS_DEPTH     (16),
        .PC_INC       (2),
        .RESET_VECTOR (16'h0),
        .TRAP_VECTOR  (16'h2)
    ) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [2:0] ctl, input logic [1:0] op);
        bus.PCWrite   = wr;
        bus.PCControl = ctl;
        bus.RStackOP  = op;
    endtask

    initial begin
        n_tot  = 0;
        n_pass = 0;
        Reset_n        = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.PCControl  = 3'd0;
        bus.RStackOP   = 2'd0;
        bus.Target     = 16'h0;
        bus.Offset     = 16'h0;
        bus.PushData   = 16'h0;
        bus.ClearFlags = 1'b0;
        #12;
        chk("rst_pc",    32'(bus.PC_out),    32'h0);
        chk("rst_rtop",  32'(bus.RTop),      32'h0);
        chk("rst_depth", 32'(bus.RDepth),    32'h0);
        chk("rst_ovf",   32'(bus.Overflow),  32'h0);
        chk("rst_unf",   32'(bus.Underflow), 32'h0);

        // 1. increment, then hold with PCWrite low
        @(negedge CLK);
        Reset_n = 1'b1;
        drive(1'b1, PC_SEL_INC, RS_NOP);
        tick();
        chk("inc1", 32'(bus.PC_out), 32'h2);
        tick();
        chk("inc2", 32'(bus.PC_out), 32'h4);
        drive(1'b0, PC_SEL_INC, RS_NOP);
        repeat (4) tick();
        chk("hold", 32'(bus.PC_out), 32'h4);

        // 2. push PC+2, run to 12, return
        drive(1'b0, PC_SEL_INC, RS_PUSH_PC);
        tick();
        chk("push_rtop",  32'(bus.RTop),   32'h6);
        chk("push_depth", 32'(bus.RDepth), 32'h1);
        drive(1'b1, PC_SEL_INC, RS_NOP);
        repeat (4) tick();
        chk("inc_to_12", 32'(bus.PC_out), 32'hC);
        drive(1'b1, PC_SEL_RSTACK, RS_POP);
        tick();
        chk("ret_pc",    32'(bus.PC_out), 32'h6);
        chk("ret_depth", 32'(bus.RDepth), 32'h0);
        chk("ret_rtop",  32'(bus.RTop),   32'h0);

        // 3. call then negative relative branch
        bus.Target = 16'h0100;
        drive(1'b1, PC_SEL_TARGET, RS_PUSH_PC);
        tick();
        chk("call_pc",   32'(bus.PC_out), 32'h100);
        chk("call_rtop", 32'(bus.RTop),   32'h8);
        bus.Offset = 16'hFFFE;
        drive(1'b1, PC_SEL_REL, RS_NOP);
        tick();
        chk("rel_pc", 32'(bus.PC_out), 32'hFE);

        // 4. fill the stack, overflow, clear priority, LIFO order on drain
        drive(1'b0, PC_SEL_INC, RS_POP);
        tick();
        chk("drain_call", 32'(bus.RDepth), 32'h0);
        drive(1'b0, PC_SEL_INC, RS_PUSH_DATA);
        for (int i = 0; i < 16; i++) begin
            bus.PushData = 16'h1000 + 16'(i);
            tick();
        end
        chk("full_depth", 32'(bus.RDepth),   32'd16);
        chk("full_rtop",  32'(bus.RTop),     32'h100F);
        chk("full_ovf",   32'(bus.Overflow), 32'h0);
        bus.PushData = 16'h2000;
        tick();
        chk("ovf_flag",  32'(bus.Overflow), 32'h1);
        chk("ovf_depth", 32'(bus.RDepth),   32'd16);
        chk("ovf_rtop",  32'(bus.RTop),     32'h100F);
        chk("ovf_pc",    32'(bus.PC_out),   TRAP ? 32'h2 : 32'hFE);
        bus.ClearFlags = 1'b1;
        drive(1'b0, PC_SEL_INC, RS_PUSH_PC);
        tick();
        chk("clr_prio_ovf", 32'(bus.Overflow), 32'h0);
        chk("clr_rtop",     32'(bus.RTop),     32'h100F);
        bus.ClearFlags = 1'b0;
        drive(1'b0, PC_SEL_INC, RS_POP);
        tick();
        chk("lifo_rtop",  32'(bus.RTop),   32'h100E);
        chk("lifo_depth", 32'(bus.RDepth), 32'd15);
        repeat (15) tick();
        chk("empty_depth", 32'(bus.RDepth),    32'h0);
        chk("empty_rtop",  32'(bus.RTop),      32'h0);
        chk("empty_unf",   32'(bus.Underflow), 32'h0);

        // 5. underflow
        tick();
        chk("unf_flag",  32'(bus.Underflow), 32'h1);
        chk("unf_depth", 32'(bus.RDepth),    32'h0);
        chk("unf_pc",    32'(bus.PC_out),    TRAP ? 32'h2 : 32'hFE);
        drive(1'b1, PC_SEL_RSTACK, RS_POP);
        tick();
        chk("ret_empty_pc", 32'(bus.PC_out), TRAP ? 32'h2 : 32'h0);
        bus.ClearFlags = 1'b1;
        drive(1'b0, PC_SEL_INC, RS_NOP);
        tick();
        chk("unf_clr", 32'(bus.Underflow), 32'h0);
        bus.ClearFlags = 1'b0;

        // 6. reserved select holds, wrap-around, async reset mid-cycle
        bus.Target = 16'hFFFE;
        drive(1'b1, PC_SEL_TARGET, RS_NOP);
        tick();
        chk("tgt_fffe", 32'(bus.PC_out), 32'hFFFE);
        drive(1'b1, 3'd5, RS_NOP);
        tick();
        chk("rsvd_hold", 32'(bus.PC_out), 32'hFFFE);
        drive(1'b1, PC_SEL_INC, RS_NOP);
        tick();
        chk("wrap_pc",  32'(bus.PC_out),    32'h0);
        chk("wrap_ovf", 32'(bus.Overflow),  32'h0);
        chk("wrap_unf", 32'(bus.Underflow), 32'h0);
        drive(1'b1, PC_SEL_INC, RS_PUSH_PC);
        tick();
        chk("pre_rst_pc",   32'(bus.PC_out), 32'h2);
        chk("pre_rst_rtop", 32'(bus.RTop),   32'h2);
        drive(1'b0, PC_SEL_INC, RS_POP);
        tick();
        tick();
        chk("pre_rst_unf", 32'(bus.Underflow), 32'h1);
        drive(1'b0, PC_SEL_INC, RS_PUSH_PC);
        tick();
        chk("pre_rst_depth", 32'(bus.RDepth), 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_pc",    32'(bus.PC_out),    32'h0);
        chk("arst_rtop",  32'(bus.RTop),      32'h0);
        chk("arst_depth", 32'(bus.RDepth),    32'h0);
        chk("arst_ovf",   32'(bus.Overflow),  32'h0);
        chk("arst_unf",   32'(bus.Underflow), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
